// File: rtl/dmem_ctrl.sv
// Synchronous handshaked data memory for the MIPS core: word/half/byte loads and stores, sub-word stores via read-modify-write.
// Optional macro ADDR_CHECK_EN flags misaligned and reserved-size accesses on rsp_err.
module dmem_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        dbg_state
);
    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // the requester holds it otherwise. rsp_valid is a one-cycle pulse with no back-pressure.
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd1, RMW = 2'd2} state_t;
    state_t state;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] req_idx;
    logic [1:0]       req_lane;
    logic             accept;
    logic             req_err;
    logic [1:0]       eff_size;
    logic             word_store;
    logic             sub_store;
    logic             addr_unused;

    assign req_idx     = req_addr[IDX_W+1:2];
    assign req_lane    = req_addr[1:0];
    assign accept      = req_valid && req_ready;
    assign addr_unused = ^req_addr[ADDR_W-1:IDX_W+2];
    assign dbg_state   = state;

    always_comb begin
`ifdef ADDR_CHECK_EN
        req_err  = (req_size == 2'b11) ||
                   (req_size == 2'b00 && req_lane != 2'b00) ||
                   (req_size == 2'b01 && req_lane[0]);
        eff_size = req_size;
`else
        req_err  = 1'b0;
        eff_size = (req_size == 2'b11) ? 2'b00 : req_size;
`endif
    end

    assign word_store = req_we && (eff_size == 2'b00) && !req_err;
    assign sub_store  = req_we && (eff_size == 2'b01 || eff_size == 2'b10) && !req_err;

    // Captured sub-word store, completed in the RMW cycle
    logic [IDX_W-1:0] rmw_idx;
    logic [1:0]       rmw_lane;
    logic             rmw_half;
    logic [15:0]      rmw_data;
    logic [31:0]      rmw_buf;
    logic [31:0]      merged;

    always_comb begin
        merged = rmw_buf;
        if (rmw_half) begin
            if (rmw_lane[1]) merged[31:16] = rmw_data;
            else             merged[15:0]  = rmw_data;
        end else begin
            merged[{rmw_lane, 3'b000} +: 8] = rmw_data[7:0];
        end
    end

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] size,
                                             input logic [1:0] lane, input logic uns);
        logic [15:0] h;
        logic [7:0]  b;
        h = lane[1] ? w[31:16] : w[15:0];
        b = w[{lane, 3'b000} +: 8];
        case (size)
            2'b01:   load_ext = uns ? {16'h0, h} : {{16{h[15]}}, h};
            2'b10:   load_ext = uns ? {24'h0, b} : {{24{b[7]}}, b};
            default: load_ext = w;
        endcase
    endfunction

    // Memory port: the RMW write is driven from state, so an async reset abandons it
    logic             mem_we;
    logic [IDX_W-1:0] mem_widx;
    logic [31:0]      mem_wdata;

    assign mem_we    = (state == RMW) || (accept && word_store);
    assign mem_widx  = (state == RMW) ? rmw_idx : req_idx;
    assign mem_wdata = (state == RMW) ? merged : req_wdata;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_widx] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            rmw_idx   <= '0;
            rmw_lane  <= 2'b00;
            rmw_half  <= 1'b0;
            rmw_data  <= 16'h0;
            rmw_buf   <= 32'h0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        if (req_err) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= 32'h0;
                            rsp_err   <= 1'b1;
                        end else if (sub_store) begin
                            state     <= RMW;
                            req_ready <= 1'b0;
                            rsp_valid <= 1'b0;
                            rmw_idx   <= req_idx;
                            rmw_lane  <= req_lane;
                            rmw_half  <= (eff_size == 2'b01);
                            rmw_data  <= req_wdata[15:0];
                            rmw_buf   <= mem[req_idx];
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= req_we ? 32'h0
                                       : load_ext(mem[req_idx], eff_size, req_lane, req_unsigned);
                        end
                    end else begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                RMW: begin
                    state     <= RESP;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a table of requests with hand-computed responses plus a reset-during-RMW sequence.
module tb_dmem_ctrl;
    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(2048)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        vec_t v;
        v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Presents a request (called just after a rising edge) and returns 1ns after its accept edge
    task automatic drive(input string name, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int waited;
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_ready_timeout: req_ready stayed 0 for %0d cycles, required 1", name, waited);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input vec_t v);
        drive(v.name, v.we, v.size, v.uns, v.addr, v.wdata);
        if (v.lat == 2) begin
            check({v.name, "_rmw_ready"}, {31'b0, req_ready}, 32'd0);
            check({v.name, "_rmw_valid"}, {31'b0, rsp_valid}, 32'd0);
            @(posedge clk); #1;
        end
        check({v.name, "_valid"}, {31'b0, rsp_valid}, 32'd1);
        check({v.name, "_rdata"}, rsp_rdata, v.exp_rdata);
        check({v.name, "_err"},   {31'b0, rsp_err}, {31'b0, v.exp_err});
    endtask

    initial begin
        logic [31:0] last_rdata;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

        // name, we, size, uns, addr, wdata, exp_rdata, exp_err, latency
        add("sw_10",     1, 2'b00, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0, 1);
        add("lw_10_a",   0, 2'b00, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 1);
        add("sb_13",     1, 2'b10, 0, 32'h13,   32'h00000080, 32'h0,        0, 2);
        add("lw_10_b",   0, 2'b00, 0, 32'h10,   32'h0,        32'h80ADBEEF, 0, 1);
        add("lb_13",     0, 2'b10, 0, 32'h13,   32'h0,        32'hFFFFFF80, 0, 1);
        add("lbu_13",    0, 2'b10, 1, 32'h13,   32'h0,        32'h00000080, 0, 1);
        add("sh_12",     1, 2'b01, 0, 32'h12,   32'h00008001, 32'h0,        0, 2);
        add("lw_10_c",   0, 2'b00, 0, 32'h10,   32'h0,        32'h8001BEEF, 0, 1);
        add("lh_12",     0, 2'b01, 0, 32'h12,   32'h0,        32'hFFFF8001, 0, 1);
        add("lhu_12",    0, 2'b01, 1, 32'h12,   32'h0,        32'h00008001, 0, 1);
        add("sw_0",      1, 2'b00, 0, 32'h0,    32'h11111111, 32'h0,        0, 1);
        add("sw_4",      1, 2'b00, 0, 32'h4,    32'h22222222, 32'h0,        0, 1);
        add("sw_8",      1, 2'b00, 0, 32'h8,    32'h33333333, 32'h0,        0, 1);
        add("sw_c",      1, 2'b00, 0, 32'hC,    32'h44444444, 32'h0,        0, 1);
        add("lw_0",      0, 2'b00, 0, 32'h0,    32'h0,        32'h11111111, 0, 1);
        add("lw_4",      0, 2'b00, 0, 32'h4,    32'h0,        32'h22222222, 0, 1);
        add("lw_8",      0, 2'b00, 0, 32'h8,    32'h0,        32'h33333333, 0, 1);
        add("lw_c",      0, 2'b00, 0, 32'hC,    32'h0,        32'h44444444, 0, 1);
        add("lw_2010",   0, 2'b00, 0, 32'h2010, 32'h0,        32'h8001BEEF, 0, 1);
        add("sb_10",     1, 2'b10, 0, 32'h10,   32'hFFFFFF5A, 32'h0,        0, 2);
        add("lw_10_d",   0, 2'b00, 0, 32'h10,   32'h0,        32'h8001BE5A, 0, 1);
        add("lb_11",     0, 2'b10, 0, 32'h11,   32'h0,        32'hFFFFFFBE, 0, 1);
        add("lbu_12",    0, 2'b10, 1, 32'h12,   32'h0,        32'h00000001, 0, 1);
        add("lh_10",     0, 2'b01, 0, 32'h10,   32'h0,        32'hFFFFBE5A, 0, 1);
`ifdef ADDR_CHECK_EN
        add("lh_11",     0, 2'b01, 0, 32'h11,   32'h0,        32'h0,        1, 1);
        add("lw_sz3",    0, 2'b11, 0, 32'h0,    32'h0,        32'h0,        1, 1);
        add("sw_11",     1, 2'b00, 0, 32'h11,   32'h12345678, 32'h0,        1, 1);
        add("lw_10_e",   0, 2'b00, 0, 32'h10,   32'h0,        32'h8001BE5A, 0, 1);
`else
        add("lh_11",     0, 2'b01, 0, 32'h11,   32'h0,        32'hFFFFBE5A, 0, 1);
        add("lw_sz3",    0, 2'b11, 0, 32'h0,    32'h0,        32'h11111111, 0, 1);
        add("sw_11",     1, 2'b00, 0, 32'h11,   32'h12345678, 32'h0,        0, 1);
        add("lw_10_e",   0, 2'b00, 0, 32'h10,   32'h0,        32'h12345678, 0, 1);
`endif
        add("sw_30",     1, 2'b00, 0, 32'h30,   32'hCAFEBABE, 32'h0,        0, 1);
        add("lw_30",     0, 2'b00, 0, 32'h30,   32'h0,        32'hCAFEBABE, 0, 1);

        // Clock/reset
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'b0, req_ready}, 32'd1);
        check("reset_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_rdata", rsp_rdata, 32'h0);
        check("reset_err",   {31'b0, rsp_err}, 32'd0);
        check("reset_state", {30'b0, dbg_state}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i]);
        last_rdata = vecs[vecs.size()-1].exp_rdata;

        // Response falls after one cycle with no request; data holds
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("idle_valid", {31'b0, rsp_valid}, 32'd0);
        check("idle_hold_rdata", rsp_rdata, last_rdata);
        check("idle_state", {30'b0, dbg_state}, 32'd0);

        // Reset pulsed during the RMW cycle of a byte store to 0x30
        drive("sb_30_rst", 1'b1, 2'b10, 1'b0, 32'h30, 32'h00000011);
        check("rmw_state", {30'b0, dbg_state}, 32'd2);
        check("rmw_ready", {31'b0, req_ready}, 32'd0);
        rst = 1'b1;
        req_valid = 1'b0;
        #2;
        check("rst_rmw_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rmw_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rmw_rdata", rsp_rdata, 32'h0);
        check("rst_rmw_err",   {31'b0, rsp_err}, 32'd0);
        check("rst_rmw_state", {30'b0, dbg_state}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_rmw_no_rsp", {31'b0, rsp_valid}, 32'd0);
        drive("lw_30_after_rst", 1'b0, 2'b00, 1'b0, 32'h30, 32'h0);
        check("lw_30_after_rst_valid", {31'b0, rsp_valid}, 32'd1);
        check("lw_30_after_rst_rdata", rsp_rdata, 32'hCAFEBABE);
        req_valid = 1'b0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
